// File: rtl/tmr_fault_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tmr_fault_pkg
// Brief    : Mode encoding, lane indices and mode-to-lane-disable mapping
//            shared by the TMR fault manager and its counters.
// Revision : 1.0 - initial release
// ============================================================================
package tmr_fault_pkg;

    typedef enum logic [2:0] {
        MODE_TMR   = 3'd0,
        MODE_DMR_A = 3'd1,
        MODE_DMR_B = 3'd2,
        MODE_DMR_C = 3'd3,
        MODE_FAIL  = 3'd4
    } mode_e;

    localparam int LANE_A = 0;
    localparam int LANE_B = 1;
    localparam int LANE_C = 2;

    function automatic logic [2:0] mode_to_lane_dis(input mode_e m);
        logic [2:0] v;
        v = 3'b000;
        case (m)
            MODE_DMR_A: v[LANE_A] = 1'b1;
            MODE_DMR_B: v[LANE_B] = 1'b1;
            MODE_DMR_C: v[LANE_C] = 1'b1;
            MODE_FAIL:  v = 3'b111;
            default:    v = 3'b000;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmr_lane_counter.sv
`default_nettype none
// ============================================================================
// Module   : tmr_lane_counter
// Brief    : Leaky saturating disagreement counter; hit pulses on the cycle
//            the next count first reaches THRESH.
// Revision : 1.0 - initial release
// ============================================================================
module tmr_lane_counter #(
    parameter int THRESH = 4,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    input  logic             frozen,
    output logic [CNT_W-1:0] cnt,
    output logic             hit
);

    localparam logic [CNT_W-1:0] c_thresh = CNT_W'(THRESH);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Simultaneous inc and dec cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!frozen) begin
            if (inc && !dec && (cnt_q != c_thresh)) begin
                cnt_d = cnt_q + 1'b1;
            end else if (dec && !inc && (cnt_q != '0)) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign hit = (cnt_d == c_thresh) && (cnt_q != c_thresh);

endmodule
`default_nettype wire

// File: rtl/tmr_fault_manager.sv
`default_nettype none
// ============================================================================
// Module   : tmr_fault_manager
// Brief    : Retires persistently disagreeing TMR lanes (TMR -> DMR -> FAIL)
//            using leaky per-lane and pair evidence counters.
// Revision : 1.0 - initial release
// ============================================================================
module tmr_fault_manager #(
    parameter int THRESH       = 4,
    parameter int CNT_W        = 4,
    parameter int DECAY_PERIOD = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       smp_vld,
    input  logic       dis_a,
    input  logic       dis_b,
    input  logic       dis_c,
    input  logic       clr,
    output logic [2:0] lane_dis,
    output logic [2:0] mode,
    output logic       tmr_error,
    output logic       fatal,
    output logic       evt
);

    import tmr_fault_pkg::*;

    localparam int               TIMER_W      = $clog2(DECAY_PERIOD);
    localparam logic [TIMER_W-1:0] c_timer_last = TIMER_W'(DECAY_PERIOD - 1);

    mode_e              mode_q, mode_d;
    logic [2:0]         lane_dis_q, lane_dis_d;
    logic               tmr_error_q, tmr_error_d;
    logic               fatal_q, fatal_d;
    logic               evt_q, evt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    logic [2:0]         w_flag;
    logic [2:0]         w_live_flag;
    logic [2:0]         w_lane_hit;
    logic [CNT_W-1:0]   w_lane_cnt [3];
    logic [CNT_W-1:0]   w_pair_cnt;
    logic               w_pair_hit;
    logic               w_wrap;
    logic               w_in_tmr;
    logic               w_in_dmr;
    logic               w_in_fail;

    assign w_flag      = {dis_c, dis_b, dis_a} & {3{smp_vld}};
    assign w_live_flag = w_flag & ~lane_dis_q;
    assign w_wrap      = smp_vld && (timer_q == c_timer_last);
    assign w_in_tmr    = (mode_q == MODE_TMR);
    assign w_in_fail   = (mode_q == MODE_FAIL);
    assign w_in_dmr    = !w_in_tmr && !w_in_fail;

    always_comb begin
        timer_d = timer_q;
        if (clr) begin
            timer_d = '0;
        end else if (smp_vld) begin
            timer_d = w_wrap ? '0 : timer_q + 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < 3; i++) begin : g_lane
            tmr_lane_counter #(
                .THRESH (THRESH),
                .CNT_W  (CNT_W)
            ) u_cnt (
                .clk    (clk),
                .rst    (rst),
                .inc    (w_flag[i]),
                .dec    (w_wrap && (w_lane_cnt[i] != '0)),
                .clr    (clr),
                .frozen (w_in_fail || lane_dis_q[i]),
                .cnt    (w_lane_cnt[i]),
                .hit    (w_lane_hit[i])
            );
        end
    endgenerate

    // Pair evidence only accumulates while degraded; cleared on the way into DMR.
    tmr_lane_counter #(
        .THRESH (THRESH),
        .CNT_W  (CNT_W)
    ) u_pair_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (|w_live_flag),
        .dec    (w_wrap && (w_pair_cnt != '0)),
        .clr    (clr || (w_in_tmr && (|w_lane_hit))),
        .frozen (!w_in_dmr),
        .cnt    (w_pair_cnt),
        .hit    (w_pair_hit)
    );

    always_comb begin
        mode_d      = mode_q;
        lane_dis_d  = lane_dis_q;
        tmr_error_d = tmr_error_q | (|w_live_flag);
        case (mode_q)
            MODE_TMR: begin
                case (w_lane_hit)
                    3'b000:  mode_d = MODE_TMR;
                    3'b001:  mode_d = MODE_DMR_A;
                    3'b010:  mode_d = MODE_DMR_B;
                    3'b100:  mode_d = MODE_DMR_C;
                    default: mode_d = MODE_FAIL;
                endcase
                // Hit mask is exactly the lane(s) to retire, including the FAIL case.
                lane_dis_d = w_lane_hit;
            end
            MODE_DMR_A, MODE_DMR_B, MODE_DMR_C: begin
                if (w_pair_hit) begin
                    mode_d     = MODE_FAIL;
                    lane_dis_d = mode_to_lane_dis(MODE_FAIL);
                end
            end
            default: mode_d = mode_q;
        endcase
        if (clr) begin
            mode_d      = MODE_TMR;
            lane_dis_d  = 3'b000;
            tmr_error_d = 1'b0;
        end
        fatal_d = (mode_d == MODE_FAIL);
        evt_d   = !clr && (mode_d != mode_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q      <= MODE_TMR;
            lane_dis_q  <= 3'b000;
            tmr_error_q <= 1'b0;
            fatal_q     <= 1'b0;
            evt_q       <= 1'b0;
            timer_q     <= '0;
        end else begin
            mode_q      <= mode_d;
            lane_dis_q  <= lane_dis_d;
            tmr_error_q <= tmr_error_d;
            fatal_q     <= fatal_d;
            evt_q       <= evt_d;
            timer_q     <= timer_d;
        end
    end

    assign lane_dis  = lane_dis_q;
    assign mode      = mode_q;
    assign tmr_error = tmr_error_q;
    assign fatal     = fatal_q;
    assign evt       = evt_q;

endmodule
`default_nettype wire

// File: tb/tb_tmr_fault_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmr_fault_manager
// Brief    : Directed and randomized checks of tmr_fault_manager against an
//            integer-level reference model of the lane-retirement rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmr_fault_manager;

    localparam int THRESH       = 4;
    localparam int CNT_W        = 4;
    localparam int DECAY_PERIOD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       smp_vld, dis_a, dis_b, dis_c, clr;
    logic [2:0] lane_dis, mode;
    logic       tmr_error, fatal, evt;

    int n_vec = 0;
    int n_err = 0;

    int m_cnt [3];
    int m_pair, m_timer, m_mode, m_dis;
    bit m_err, m_evt;

    tmr_fault_manager #(
        .THRESH       (THRESH),
        .CNT_W        (CNT_W),
        .DECAY_PERIOD (DECAY_PERIOD)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .smp_vld   (smp_vld),
        .dis_a     (dis_a),
        .dis_b     (dis_b),
        .dis_c     (dis_c),
        .clr       (clr),
        .lane_dis  (lane_dis),
        .mode      (mode),
        .tmr_error (tmr_error),
        .fatal     (fatal),
        .evt       (evt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        m_pair  = 0;
        m_timer = 0;
        m_mode  = 0;
        m_dis   = 0;
        m_err   = 1'b0;
        m_evt   = 1'b0;
    endtask

    function automatic int bump(input int old, input bit up, input bit wrap);
        bit down;
        down = wrap && (old > 0);
        if (up && !down) return (old + 1 > THRESH) ? THRESH : old + 1;
        if (down && !up) return old - 1;
        return old;
    endfunction

    task automatic model_step(input bit v, input bit a, input bit b, input bit c, input bit k);
        int  old_mode, old, reached, n_reached, which;
        bit  wrap, any_live;
        bit  fl [3];
        fl[0] = a; fl[1] = b; fl[2] = c;
        old_mode = m_mode;
        if (k) begin
            model_reset();
            return;
        end
        if (v) begin
            wrap     = (m_timer == DECAY_PERIOD - 1);
            m_timer  = wrap ? 0 : m_timer + 1;
            any_live = 1'b0;
            for (int i = 0; i < 3; i++)
                if (fl[i] && !m_dis[i]) any_live = 1'b1;
            if (any_live) m_err = 1'b1;
            if (m_mode != 4) begin
                reached   = 0;
                n_reached = 0;
                which     = 0;
                for (int i = 0; i < 3; i++) begin
                    if (!m_dis[i]) begin
                        old      = m_cnt[i];
                        m_cnt[i] = bump(old, fl[i], wrap);
                        if (old < THRESH && m_cnt[i] == THRESH) begin
                            reached = reached | (1 << i);
                            n_reached++;
                            which = i;
                        end
                    end
                end
                if (m_mode == 0) begin
                    if (n_reached == 1) begin
                        m_mode = which + 1;
                        m_dis  = reached;
                        m_pair = 0;
                    end else if (n_reached >= 2) begin
                        m_mode = 4;
                        m_dis  = reached;
                    end
                end else begin
                    old    = m_pair;
                    m_pair = bump(old, any_live, wrap);
                    if (old < THRESH && m_pair == THRESH) begin
                        m_mode = 4;
                        m_dis  = 7;
                    end
                end
            end
        end
        m_evt = (m_mode != old_mode);
    endtask

    task automatic cycle(input bit v, input bit a, input bit b, input bit c, input bit k);
        smp_vld = v; dis_a = a; dis_b = b; dis_c = c; clr = k;
        model_step(v, a, b, c, k);
        @(posedge clk);
        #1;
        check("mode", mode, m_mode);
        check("lane_dis", lane_dis, m_dis[2:0]);
        check("err_fatal_evt", {tmr_error, fatal, evt}, {m_err, (m_mode == 4), m_evt});
    endtask

    task automatic repeat_cycle(input int n, input bit v, input bit a, input bit b, input bit c);
        for (int i = 0; i < n; i++) cycle(v, a, b, c, 1'b0);
    endtask

    initial begin
        int bad, bad2, p_bad, p_other;
        bit ra, rb, rc, rv, rk;

        rst = 1'b0; smp_vld = 1'b0; dis_a = 1'b0; dis_b = 1'b0; dis_c = 1'b0; clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {lane_dis, mode, tmr_error, fatal, evt}, 9'h000);
        rst = 1'b1;

        // Lane A retirement after four disagreements
        repeat_cycle(4, 1, 1, 0, 0);
        check("t1_mode", mode, 1);
        check("t1_lane_dis", lane_dis, 3'b001);
        check("t1_evt_err", {evt, tmr_error}, 2'b11);
        cycle(0, 0, 0, 0, 0);
        check("t1_evt_pulse", evt, 1'b0);
        cycle(0, 0, 0, 0, 1);
        check("clr_state", {lane_dis, mode, tmr_error, fatal, evt}, 9'h000);

        // Decay removes one count of lane B evidence
        repeat_cycle(3, 1, 0, 1, 0);
        repeat_cycle(8, 1, 0, 0, 0);
        check("t2_still_tmr", mode, 0);
        repeat_cycle(2, 1, 0, 1, 0);
        check("t2_dmr_b", mode, 2);
        check("t2_lane_dis", lane_dis, 3'b010);
        cycle(0, 0, 0, 0, 1);

        // Two lanes hit together
        repeat_cycle(4, 1, 1, 0, 1);
        check("t3_mode", mode, 4);
        check("t3_lane_dis_fatal", {lane_dis, fatal}, 4'b1011);
        cycle(0, 0, 0, 0, 1);

        // DMR_A ignores lane A, then pair fails on lane B
        repeat_cycle(4, 1, 1, 0, 0);
        repeat_cycle(20, 1, 1, 0, 0);
        check("t4_hold_dmr_a", {mode, lane_dis}, {3'd1, 3'b001});
        repeat_cycle(4, 1, 0, 1, 0);
        check("t4_fail", {mode, lane_dis, fatal}, {3'd4, 3'b111, 1'b1});
        cycle(0, 0, 0, 0, 1);

        // clr wins over a threshold hit in the same cycle
        repeat_cycle(3, 1, 1, 0, 0);
        cycle(1, 1, 0, 0, 1);
        check("t5_clr_wins", {lane_dis, mode, tmr_error, fatal, evt}, 9'h000);
        cycle(1, 1, 0, 0, 0);
        check("t5_cnt_cleared", mode, 0);

        // Asynchronous reset in DMR_C
        repeat_cycle(4, 1, 0, 0, 1);
        check("t6_dmr_c", {mode, lane_dis}, {3'd3, 3'b100});
        smp_vld = 1'b0; dis_c = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("t6_async_rst", {lane_dis, mode, tmr_error, fatal, evt}, 9'h000);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        cycle(0, 0, 0, 0, 0);
        check("t6_after_release", mode, 0);

        // Randomized segments with a preferred faulty lane (3 = none)
        for (int seg = 0; seg < 60; seg++) begin
            bad     = $urandom_range(0, 3);
            bad2    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : 3;
            p_bad   = $urandom_range(20, 70);
            p_other = $urandom_range(0, 8);
            for (int i = 0; i < 48; i++) begin
                rv = ($urandom_range(0, 99) < 80);
                ra = ($urandom_range(0, 99) < ((bad == 0 || bad2 == 0) ? p_bad : p_other));
                rb = ($urandom_range(0, 99) < ((bad == 1 || bad2 == 1) ? p_bad : p_other));
                rc = ($urandom_range(0, 99) < ((bad == 2 || bad2 == 2) ? p_bad : p_other));
                rk = ($urandom_range(0, 59) == 0);
                cycle(rv, ra, rb, rc, rk);
            end
            if ($urandom_range(0, 1) == 1) cycle(0, 0, 0, 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
